// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants for the decode, ALU and writeback stages.
package riscv_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned INST_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = $clog2(NREGS);

  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_MSB = 24;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 7;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

endpackage

// File: rtl/reg_file.sv
// NREGS x DATA_W register file: two async read ports, one sync write port,
// async clear, x0 hardwired to zero.
module reg_file
  import riscv_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_raddr1,
  input  logic [ADDR_W-1:0] in_raddr2,
  output logic [DATA_W-1:0] out_rdata1,
  output logic [DATA_W-1:0] out_rdata2
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Storage: cleared on reset, writes to x0 are dropped.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (in_we && (in_waddr != '0)) begin
      regs_q[in_waddr] <= in_wdata;
    end
  end

  // Async reads; x0 forced to zero regardless of storage contents.
  always_comb begin
    out_rdata1 = (in_raddr1 == '0) ? '0 : regs_q[in_raddr1];
    out_rdata2 = (in_raddr2 == '0) ? '0 : regs_q[in_raddr2];
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode/operand-fetch stage: one-entry pipeline register toward the ALU,
// writeback bypass at accept and operand refresh while stalled.
module decode_regfile
  import riscv_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_inst_valid,
  output logic              out_inst_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_r1,
  output logic [DATA_W-1:0] out_r2,
  input  logic              in_wb_en,
  input  logic [ADDR_W-1:0] in_wb_addr,
  input  logic [DATA_W-1:0] in_wb_data
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [DATA_W-1:0] rd1, rd2;
  logic [ADDR_W-1:0] rs1, rs2, held_rs1, held_rs2;
  logic              accept, stall, wb_hit;

  assign rs1      = in_inst[RS1_MSB:RS1_LSB];
  assign rs2      = in_inst[RS2_MSB:RS2_LSB];
  assign held_rs1 = inst_q[RS1_MSB:RS1_LSB];
  assign held_rs2 = inst_q[RS2_MSB:RS2_LSB];

  assign out_inst_ready = ~valid_q | in_ready;
  assign accept         = in_inst_valid & out_inst_ready;
  assign stall          = valid_q & ~in_ready;
  assign wb_hit         = in_wb_en & (in_wb_addr != '0);

  reg_file u_rf (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_we      (in_wb_en),
    .in_waddr   (in_wb_addr),
    .in_wdata   (in_wb_data),
    .in_raddr1  (rs1),
    .in_raddr2  (rs2),
    .out_rdata1 (rd1),
    .out_rdata2 (rd2)
  );

  // Next bundle: load with bypass on accept, clear valid on drain, refresh
  // held operands from a matching writeback while stalled.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    if (accept) begin
      valid_d = 1'b1;
      inst_d  = in_inst;
      r1_d    = (wb_hit && (in_wb_addr == rs1)) ? in_wb_data : rd1;
      r2_d    = (wb_hit && (in_wb_addr == rs2)) ? in_wb_data : rd2;
    end else begin
      if (in_ready) valid_d = 1'b0;
      if (stall && wb_hit && (in_wb_addr == held_rs1)) r1_d = in_wb_data;
      if (stall && wb_hit && (in_wb_addr == held_rs2)) r2_d = in_wb_data;
    end
  end

  // Pipeline register toward the ALU.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_r1    = r1_q;
  assign out_r2    = r2_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile with hand-computed expectations.
module tb_decode_regfile;
  import riscv_pkg::*;

  logic              clk;
  logic              rst;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic              valid;
  logic              ready;
  logic [INST_W-1:0] o_inst;
  logic [DATA_W-1:0] o_r1, o_r2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  decode_regfile dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_inst_valid  (inst_valid),
    .out_inst_ready (inst_ready),
    .in_inst        (inst),
    .out_valid      (valid),
    .in_ready       (ready),
    .out_inst       (o_inst),
    .out_r1         (o_r1),
    .out_r2         (o_r2),
    .in_wb_en       (wb_en),
    .in_wb_addr     (wb_addr),
    .in_wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] s1,
                                         input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, rd, OPC_RTYPE};
  endfunction

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = '0; ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_r1", 32'(o_r1), 32'd0);
    check("rst_ready", 32'(inst_ready), 32'd1);
    rst = 1'b0;
    step();

    // Write then read
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 8'h12;
    step();
    wb_addr = 5'd4; wb_data = 8'h34;
    step();
    wb_en = 1'b0;
    inst_valid = 1'b1; inst = 32'h004182B3;
    #1;
    check("wr_ready", 32'(inst_ready), 32'd1);
    step();
    inst_valid = 1'b0;
    check("wr_valid", 32'(valid), 32'd1);
    check("wr_inst", o_inst, 32'h004182B3);
    check("wr_r1", 32'(o_r1), 32'h12);
    check("wr_r2", 32'(o_r2), 32'h34);

    // Stall with refresh; offered instruction must not be taken
    #1;
    check("st_ready", 32'(inst_ready), 32'd0);
    inst_valid = 1'b1; inst = mk_add(5'd9, 5'd7, 5'd8);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 8'h77;
    step();
    wb_en = 1'b0;
    check("st_r2", 32'(o_r2), 32'h77);
    check("st_r1", 32'(o_r1), 32'h12);
    check("st_inst", o_inst, 32'h004182B3);
    check("st_valid", 32'(valid), 32'd1);
    check("st_ready2", 32'(inst_ready), 32'd0);
    step();
    check("st_hold_inst", o_inst, 32'h004182B3);

    // Bypass on accept (x4 was written during the stall)
    ready = 1'b1;
    inst = 32'h004182B3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 8'hA5;
    step();
    check("bp_r1", 32'(o_r1), 32'hA5);
    check("bp_r2", 32'(o_r2), 32'h77);
    inst = mk_add(5'd5, 5'd0, 5'd3);
    wb_addr = 5'd0; wb_data = 8'hFF;
    step();
    check("bp_x0_r1", 32'(o_r1), 32'd0);
    check("bp_x0_r2", 32'(o_r2), 32'hA5);
    check("bp_x0_inst", o_inst, 32'h003002B3);

    // Set up x2, draining the current bundle
    inst_valid = 1'b0;
    wb_addr = 5'd2; wb_data = 8'h5C;
    step();
    check("pre_valid", 32'(valid), 32'd0);

    // Throughput: 10 back-to-back ADDs, each bypassing x1
    inst_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inst = mk_add(5'(i + 6), 5'd1, 5'd2);
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 8'(8'h40 + i);
      #1;
      check("tp_ready", 32'(inst_ready), 32'd1);
      step();
      check("tp_valid", 32'(valid), 32'd1);
      check("tp_inst", o_inst, mk_add(5'(i + 6), 5'd1, 5'd2));
      check("tp_r1", 32'(o_r1), 32'(8'h40 + i));
      check("tp_r2", 32'(o_r2), 32'h5C);
    end

    // Drain
    inst_valid = 1'b0; wb_en = 1'b0;
    step();
    check("dr_valid", 32'(valid), 32'd0);
    check("dr_ready", 32'(inst_ready), 32'd1);
    check("dr_inst_kept", o_inst, mk_add(5'd15, 5'd1, 5'd2));
    check("dr_r1_kept", 32'(o_r1), 32'h49);

    // Reset mid-stream with a bundle held
    ready = 1'b0;
    inst_valid = 1'b1; inst = 32'h004182B3;
    step();
    inst_valid = 1'b0;
    check("mr_pre_valid", 32'(valid), 32'd1);
    check("mr_pre_r1", 32'(o_r1), 32'hA5);
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_r1", 32'(o_r1), 32'd0);
    check("mr_r2", 32'(o_r2), 32'd0);
    step();
    rst = 1'b0;
    inst_valid = 1'b1; inst = 32'h004182B3;
    step();
    inst_valid = 1'b0;
    check("mr_acc_valid", 32'(valid), 32'd1);
    check("mr_acc_r1", 32'(o_r1), 32'd0);
    check("mr_acc_r2", 32'(o_r2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
